// File: rtl/pulp_cluster_package.sv
// Shared types for cluster AXI port isolation sequencing.
package pulp_cluster_package;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } isolate_state_e;

    function automatic int unsigned txn_cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/cluster_txn_counter.sv
// Saturating up/down counter of outstanding AXI transactions.
module cluster_txn_counter
    import pulp_cluster_package::*;
#(
    parameter int unsigned MAX_TXNS = 8,
    parameter int unsigned W        = txn_cnt_width(MAX_TXNS)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] count_q, count_d;

    assign full_o       = (count_q == W'(MAX_TXNS));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign count_next_o = count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A response with nothing outstanding is a protocol error upstream.
    dec_at_zero: assert property (
        @(posedge clk_i) disable iff (rst_i) !(dec_i && !inc_i && empty_o)
    );

endmodule

// File: rtl/cluster_axi_isolate_ctrl.sv
// Per-port AXI drain/isolation sequencer with outstanding-txn caps.
// Optional drain timeout: define CLUSTER_AXI_ISOLATE_TIMEOUT_EN.
module cluster_axi_isolate_ctrl
    import pulp_cluster_package::*;
#(
    parameter int unsigned MAX_TXNS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           isolate_req_i,
    output logic                           isolated_o,
    input  logic                           slv_aw_valid_i,
    output logic                           slv_aw_ready_o,
    output logic                           mst_aw_valid_o,
    input  logic                           mst_aw_ready_i,
    input  logic                           slv_ar_valid_i,
    output logic                           slv_ar_ready_o,
    output logic                           mst_ar_valid_o,
    input  logic                           mst_ar_ready_i,
    input  logic                           b_valid_i,
    input  logic                           b_ready_i,
    input  logic                           r_valid_i,
    input  logic                           r_ready_i,
    input  logic                           r_last_i,
    output logic [$clog2(MAX_TXNS+1)-1:0]  wr_outstanding_o,
    output logic [$clog2(MAX_TXNS+1)-1:0]  rd_outstanding_o,
    output logic                           drain_timeout_o
);

    localparam int unsigned CW = txn_cnt_width(MAX_TXNS);

    isolate_state_e state_q;
    logic           isolated_q;
    logic           aw_pending_q, aw_pending_d;
    logic           ar_pending_q, ar_pending_d;
    logic           aw_allow, ar_allow;
    logic           aw_hs, ar_hs, b_hs, r_hs;
    logic           wr_full, wr_empty, rd_full, rd_empty;
    logic [CW-1:0]  wr_next, rd_next;
    logic           drained;
    logic           unused_flags;

    assign aw_allow = aw_pending_q | ((state_q == RUN) & ~wr_full);
    assign ar_allow = ar_pending_q | ((state_q == RUN) & ~rd_full);

    assign mst_aw_valid_o = slv_aw_valid_i & aw_allow;
    assign slv_aw_ready_o = mst_aw_ready_i & aw_allow;
    assign mst_ar_valid_o = slv_ar_valid_i & ar_allow;
    assign slv_ar_ready_o = mst_ar_ready_i & ar_allow;

    assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i;

    // Once presented downstream, a request stays allowed until accepted.
    assign aw_pending_d = aw_hs ? 1'b0 : (mst_aw_valid_o | aw_pending_q);
    assign ar_pending_d = ar_hs ? 1'b0 : (mst_ar_valid_o | ar_pending_q);

    assign drained = (wr_next == '0) && (rd_next == '0)
                   && !aw_pending_d && !ar_pending_d;

    cluster_txn_counter #(.MAX_TXNS(MAX_TXNS), .W(CW)) i_wr_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (aw_hs),
        .dec_i        (b_hs),
        .count_o      (wr_outstanding_o),
        .count_next_o (wr_next),
        .full_o       (wr_full),
        .empty_o      (wr_empty)
    );

    cluster_txn_counter #(.MAX_TXNS(MAX_TXNS), .W(CW)) i_rd_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (ar_hs),
        .dec_i        (r_hs),
        .count_o      (rd_outstanding_o),
        .count_next_o (rd_next),
        .full_o       (rd_full),
        .empty_o      (rd_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_pending_q <= 1'b0;
            ar_pending_q <= 1'b0;
        end else begin
            aw_pending_q <= aw_pending_d;
            ar_pending_q <= ar_pending_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            isolated_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (isolate_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!isolate_req_i) begin
                        state_q <= RUN;
                    end else if (drained) begin
                        state_q    <= ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ISOLATED: begin
                    if (!isolate_req_i) begin
                        state_q    <= RUN;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o = isolated_q;

`ifdef CLUSTER_AXI_ISOLATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;
    logic          stay_drain;

    assign stay_drain = (state_q == DRAIN) && isolate_req_i && !drained;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if ((state_q == DRAIN) && (tmo_cnt_q == TMO_LAST)) tmo_q <= 1'b1;
            if (!stay_drain) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TMO_LAST) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign drain_timeout_o = tmo_q;
    assign unused_flags    = wr_empty | rd_empty;
`else
    assign drain_timeout_o = 1'b0;
    assign unused_flags    = wr_empty | rd_empty | (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_cluster_axi_isolate_ctrl.sv
// Randomized bench for cluster_axi_isolate_ctrl with a transaction-level model.
module tb_cluster_axi_isolate_ctrl;

    localparam int MAX = 8;
    localparam int TMO = 16;
    localparam int CW  = $clog2(MAX + 1);
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_ISO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic isolate_req, isolated;
    logic slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic b_valid, b_ready, r_valid, r_ready, r_last;
    logic [CW-1:0] wr_out, rd_out;
    logic tmo_flag;

    always #5 clk = ~clk;

    cluster_axi_isolate_ctrl #(.MAX_TXNS(MAX), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .isolate_req_i    (isolate_req),
        .isolated_o       (isolated),
        .slv_aw_valid_i   (slv_aw_valid),
        .slv_aw_ready_o   (slv_aw_ready),
        .mst_aw_valid_o   (mst_aw_valid),
        .mst_aw_ready_i   (mst_aw_ready),
        .slv_ar_valid_i   (slv_ar_valid),
        .slv_ar_ready_o   (slv_ar_ready),
        .mst_ar_valid_o   (mst_ar_valid),
        .mst_ar_ready_i   (mst_ar_ready),
        .b_valid_i        (b_valid),
        .b_ready_i        (b_ready),
        .r_valid_i        (r_valid),
        .r_ready_i        (r_ready),
        .r_last_i         (r_last),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out),
        .drain_timeout_o  (tmo_flag)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the port.
    int m_wr, m_rd, m_ph, m_dcyc;
    bit m_awp, m_arp, m_iso, m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit aw_ok();
        return m_awp || (m_ph == PH_RUN && m_wr < MAX);
    endfunction

    function automatic bit ar_ok();
        return m_arp || (m_ph == PH_RUN && m_rd < MAX);
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_ph = PH_RUN; m_dcyc = 0;
        m_awp = 0; m_arp = 0; m_iso = 0; m_tmo = 0;
    endtask

    task automatic idle_inputs();
        isolate_req = 0;
        slv_aw_valid = 0; mst_aw_ready = 0;
        slv_ar_valid = 0; mst_ar_ready = 0;
        b_valid = 0; b_ready = 0;
        r_valid = 0; r_ready = 0; r_last = 0;
    endtask

    task automatic compare();
        chk("mst_aw_valid", mst_aw_valid, slv_aw_valid && aw_ok());
        chk("slv_aw_ready", slv_aw_ready, mst_aw_ready && aw_ok());
        chk("mst_ar_valid", mst_ar_valid, slv_ar_valid && ar_ok());
        chk("slv_ar_ready", slv_ar_ready, mst_ar_ready && ar_ok());
        chk("isolated", isolated, m_iso);
        chk("wr_count", wr_out, m_wr);
        chk("rd_count", rd_out, m_rd);
        chk("timeout", tmo_flag, m_tmo);
    endtask

    task automatic model_update();
        bit aw_mv, ar_mv, awhs, arhs, bhs, rhs, idle;
        int wn, rn, pn;
        aw_mv = slv_aw_valid && aw_ok();
        ar_mv = slv_ar_valid && ar_ok();
        awhs  = aw_mv && mst_aw_ready;
        arhs  = ar_mv && mst_ar_ready;
        bhs   = b_valid && b_ready;
        rhs   = r_valid && r_ready && r_last;
        wn = m_wr + int'(awhs) - int'(bhs);
        rn = m_rd + int'(arhs) - int'(rhs);
        if (wn < 0) wn = 0;
        if (rn < 0) rn = 0;
        if (awhs) m_awp = 0; else if (aw_mv) m_awp = 1;
        if (arhs) m_arp = 0; else if (ar_mv) m_arp = 1;
        idle = (wn == 0) && (rn == 0) && !m_awp && !m_arp;
        pn = m_ph;
        if (!isolate_req) pn = PH_RUN;
        else if (m_ph == PH_RUN) pn = PH_DRAIN;
        else if (m_ph == PH_DRAIN && idle) pn = PH_ISO;
`ifdef CLUSTER_AXI_ISOLATE_TIMEOUT_EN
        if (m_ph == PH_DRAIN) begin
            m_dcyc++;
            if (m_dcyc >= TMO) m_tmo = 1;
        end
        if (pn != PH_DRAIN) m_dcyc = 0;
`endif
        m_wr = wn; m_rd = rn; m_ph = pn;
        m_iso = (pn == PH_ISO);
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("reset_isolated", isolated, 0);
        chk("reset_wr", wr_out, 0);
        chk("reset_rd", rd_out, 0);
        chk("reset_timeout", tmo_flag, 0);

        // Read cap: 8 accepted, 9th stalls until one R last returns.
        slv_ar_valid = 1; mst_ar_ready = 1;
        repeat (8) step();
        chk("ar_full_count", rd_out, 8);
        chk("ar_9th_stalled", slv_ar_ready, 0);
        r_valid = 1; r_ready = 1; r_last = 1;
        step();
        r_valid = 0;
        #1;
        chk("ar_after_r_count", rd_out, 7);
        chk("ar_9th_ready", slv_ar_ready, 1);
        step();
        chk("ar_9th_accepted", rd_out, 8);
        slv_ar_valid = 0; r_valid = 1;
        repeat (8) step();
        r_valid = 0; r_ready = 0; r_last = 0;
        chk("rd_drained", rd_out, 0);

        // Four writes then isolate; B one per cycle.
        slv_aw_valid = 1; mst_aw_ready = 1;
        repeat (4) step();
        chk("aw_four", wr_out, 4);
        slv_aw_valid = 0; isolate_req = 1;
        step();
        slv_aw_valid = 1; b_valid = 1; b_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_aw_blocked", mst_aw_valid, 0);
            chk("drain_not_isolated", isolated, 0);
            step();
        end
        b_valid = 0; slv_aw_valid = 0;
        chk("isolated_after_4th_b", isolated, 1);
        isolate_req = 0;
        step();
        chk("released", isolated, 0);

        // Simultaneous AW and B at wr=3.
        slv_aw_valid = 1;
        repeat (3) step();
        b_valid = 1;
        step();
        chk("aw_b_same_cycle", wr_out, 3);
        slv_aw_valid = 0;
        repeat (3) step();
        b_valid = 0;
        chk("wr_drained", wr_out, 0);

        // AW presented but not accepted when isolation is requested.
        slv_aw_valid = 1; mst_aw_ready = 0;
        step();
        isolate_req = 1;
        step();
        #1;
        chk("pending_held", mst_aw_valid, 1);
        step();
        chk("pending_not_isolated", isolated, 0);
        mst_aw_ready = 1;
        step();
        chk("pending_accepted", wr_out, 1);
        slv_aw_valid = 0; mst_aw_ready = 0; b_valid = 1;
        step();
        b_valid = 0;
        chk("pending_isolated", isolated, 1);
        isolate_req = 0;
        step();

        // Idle port: one-cycle pulse aborts, held request isolates in 2 cycles.
        isolate_req = 1;
        step();
        isolate_req = 0;
        step();
        chk("pulse_no_iso_a", isolated, 0);
        step();
        chk("pulse_no_iso_b", isolated, 0);
        isolate_req = 1;
        step();
        chk("idle_iso_1cyc", isolated, 0);
        step();
        chk("idle_iso_2cyc", isolated, 1);
        isolate_req = 0;
        step();
        chk("idle_release", isolated, 0);

`ifdef CLUSTER_AXI_ISOLATE_TIMEOUT_EN
        // One read never completes: timeout after TMO drain cycles.
        slv_ar_valid = 1; mst_ar_ready = 1;
        step();
        slv_ar_valid = 0; isolate_req = 1;
        step();
        repeat (TMO - 1) step();
        chk("tmo_not_yet", tmo_flag, 0);
        step();
        chk("tmo_set", tmo_flag, 1);
        chk("tmo_not_isolated", isolated, 0);
        r_valid = 1; r_ready = 1; r_last = 1;
        step();
        r_valid = 0;
        step();
        chk("tmo_then_isolated", isolated, 1);
        isolate_req = 0;
        step();
`endif

        // Randomized traffic with isolate toggling and one async reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                rst = 1;
                idle_inputs();
                model_reset();
                #1;
                chk("async_rst_wr", wr_out, 0);
                chk("async_rst_iso", isolated, 0);
                @(posedge clk);
                #1 rst = 0;
            end
            if ($urandom_range(0, 39) == 0) isolate_req = ~isolate_req;
            slv_aw_valid = m_awp ? 1'b1 : 1'($urandom_range(0, 1));
            slv_ar_valid = m_arp ? 1'b1 : 1'($urandom_range(0, 1));
            mst_aw_ready = 1'($urandom_range(0, 1));
            mst_ar_ready = 1'($urandom_range(0, 1));
            b_valid = (m_wr > 0) && ($urandom_range(0, 2) == 0);
            b_ready = 1'($urandom_range(0, 1));
            r_valid = (m_rd > 0) && ($urandom_range(0, 1) == 0);
            r_ready = 1'($urandom_range(0, 1));
            r_last  = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
